// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: opcode values,
// FSM state encoding and the operand-usage decode.
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    // True when the instruction consumes its rt field as a source operand.
    // ADDI/LW use rt as a destination, so they only read rs.
    function automatic logic op_reads_rt(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
            OP_SW, OP_BEQ, OP_BNE: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// RAW hazard detector: compares the ID-stage sources against the EX-stage
// destination. Register $0 is hardwired to zero and never creates a hazard.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [3:0] id_op,
    input  logic [1:0] id_rs,
    input  logic [1:0] id_rt,
    input  logic       ex_regwrite,
    input  logic [1:0] ex_wr,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_wr == id_rs);
    assign rt_match = op_reads_rt(id_op) && (ex_wr == id_rt);
    assign hazard   = ex_regwrite && (ex_wr != 2'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 3-stage IF/ID/EX core. Inserts IDEX bubbles on
// RAW hazards, redirects and flushes on taken branches, and supports a debug
// freeze with single-step. Outputs are Mealy; state moves on the falling
// clock edge together with the pipeline registers.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int STALL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_op,
    input  logic [1:0]       id_rs,
    input  logic [1:0]       id_rt,
    input  logic             ex_regwrite,
    input  logic [1:0]       ex_wr,
    input  logic             ex_br_taken,
    input  logic             dbg_freeze,
    input  logic             dbg_step,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             wb_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Bubbles still owed after the first one, loaded when a hazard is seen.
    localparam logic [1:0] STALL_INIT = 2'(STALL_CYCLES - 1);

    state_t     state_q;
    logic [1:0] stall_left;

    logic   hazard;
    logic   frozen;
    logic   stepping;
    state_t eff_state;
    logic   take_branch;
    logic   do_stall;
    logic   do_hazard;

    state_t     nxt_state;
    state_t     run_next;
    logic [1:0] nxt_left;
    logic       stall_inc;
    logic       flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_detect u_hazard_detect (
        .id_op       (id_op),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_regwrite (ex_regwrite),
        .ex_wr       (ex_wr),
        .hazard      (hazard)
    );

    assign state = state_q;

    // Classify this cycle: frozen, or acting as the (resumed) RUN/STALL state.
    always_comb begin
        stepping    = (state_q == ST_FREEZE) && dbg_step;
        frozen      = (state_q == ST_FREEZE) && !dbg_step;
        if (state_q == ST_FREEZE) begin
            eff_state = (stall_left != 2'd0) ? ST_STALL : ST_RUN;
        end else begin
            eff_state = state_q;
        end
        take_branch = !frozen && ex_br_taken;
        do_stall    = !frozen && !ex_br_taken && (eff_state == ST_STALL);
        do_hazard   = !frozen && !ex_br_taken && (eff_state != ST_STALL) && hazard;
    end

    // Stage enables and flush/bubble controls derived from the cycle class.
    always_comb begin
        pc_write    = 1'b1;
        pc_sel      = 1'b0;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        wb_en       = 1'b1;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            wb_en       = 1'b0;
        end else if (frozen) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            wb_en       = 1'b0;
        end else if (take_branch) begin
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (do_stall || do_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Next state, stall down-counter and counter increments.
    always_comb begin
        run_next  = ST_RUN;
        nxt_left  = stall_left;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (take_branch) begin
            // The hazarding instruction is flushed, so any owed bubbles go too.
            flush_inc = 1'b1;
            nxt_left  = 2'd0;
            run_next  = ST_RUN;
        end else if (do_stall) begin
            stall_inc = 1'b1;
            nxt_left  = (stall_left != 2'd0) ? stall_left - 2'd1 : 2'd0;
            run_next  = (stall_left > 2'd1) ? ST_STALL : ST_RUN;
        end else if (do_hazard) begin
            stall_inc = 1'b1;
            nxt_left  = STALL_INIT;
            run_next  = (STALL_INIT != 2'd0) ? ST_STALL : ST_RUN;
        end

        if (frozen) begin
            nxt_state = dbg_freeze ? ST_FREEZE : eff_state;
        end else if (stepping) begin
            nxt_state = dbg_freeze ? ST_FREEZE : run_next;
        end else if (dbg_freeze && !ex_br_taken) begin
            nxt_state = ST_FREEZE;
        end else begin
            nxt_state = run_next;
        end
    end

    // Control state and saturating event counters.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            stall_left <= 2'd0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state_q    <= nxt_state;
            stall_left <= nxt_left;
            if (stall_inc) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_inc) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver computes each cycle's
// expected response from a rule-level model and queues it; a monitor pops
// and compares the DUT outputs once per cycle.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int SC    = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam int ACT_FLOW   = 0;
    localparam int ACT_BUBBLE = 1;
    localparam int ACT_BRANCH = 2;
    localparam int ACT_HOLD   = 3;

    typedef struct packed {
        logic [6:0]       ctl;
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [3:0]       id_op;
    logic [1:0]       id_rs;
    logic [1:0]       id_rt;
    logic             ex_regwrite;
    logic [1:0]       ex_wr;
    logic             ex_br_taken;
    logic             dbg_freeze;
    logic             dbg_step;
    logic             pc_write;
    logic             pc_sel;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             wb_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    exp_t sb[$];

    // Reference model state: mode 0=run 1=stall 2=freeze, owed bubbles, counts.
    int m_mode  = 0;
    int m_left  = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .STALL_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_op       (id_op),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_regwrite (ex_regwrite),
        .ex_wr       (ex_wr),
        .ex_br_taken (ex_br_taken),
        .dbg_freeze  (dbg_freeze),
        .dbg_step    (dbg_step),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_write  (idex_write),
        .idex_bubble (idex_bubble),
        .wb_en       (wb_en),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_hazard(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                                        input bit rw, input logic [1:0] wr);
        bit reads_rt;
        reads_rt = (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9});
        return rw && (wr != 0) && ((wr == rs) || (reads_rt && (wr == rt)));
    endfunction

    // Drive one cycle of inputs, queue the expected response, advance the model.
    task automatic cyc(input bit rst, input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                       input bit rw, input logic [1:0] wr, input bit tk, input bit frz, input bit stp);
        exp_t e;
        int   act;
        int   eff;
        int   nmode;
        int   nleft;
        @(posedge clk);
        #1;
        rst_n = ~rst; id_op = op; id_rs = rs; id_rt = rt; ex_regwrite = rw;
        ex_wr = wr; ex_br_taken = tk; dbg_freeze = frz; dbg_step = stp;
        if (rst) begin
            e.ctl = 7'b0001010; e.st = 2'd0; e.sc = '0; e.fc = '0;
            sb.push_back(e);
            m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
            return;
        end
        e.st = 2'(m_mode); e.sc = CNT_W'(m_stall); e.fc = CNT_W'(m_flush);
        eff = (m_mode == 2) ? ((m_left > 0) ? 1 : 0) : m_mode;
        if (m_mode == 2 && !stp)                      act = ACT_HOLD;
        else if (tk)                                  act = ACT_BRANCH;
        else if (eff == 1 || model_hazard(op, rs, rt, rw, wr)) act = ACT_BUBBLE;
        else                                          act = ACT_FLOW;
        // {pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_bubble, wb_en}
        case (act)
            ACT_FLOW:   e.ctl = 7'b1010101;
            ACT_BUBBLE: e.ctl = 7'b0000111;
            ACT_BRANCH: e.ctl = 7'b1111111;
            default:    e.ctl = 7'b0000000;
        endcase
        sb.push_back(e);
        nleft = m_left;
        nmode = 0;
        case (act)
            ACT_HOLD:   nmode = frz ? 2 : eff;
            ACT_BRANCH: begin
                m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                nleft = 0;
            end
            ACT_BUBBLE: begin
                m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                nleft = (eff == 1) ? m_left - 1 : SC - 1;
                nmode = (nleft > 0) ? 1 : 0;
            end
            default: nmode = 0;
        endcase
        if (act != ACT_HOLD) begin
            if (m_mode == 2) nmode = frz ? 2 : nmode;
            else if (!tk && frz) nmode = 2;
        end
        m_mode = nmode;
        m_left = nleft;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        #3;
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: one comparison group per clock, sampled before the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cycle++;
                checks++;
                if ({pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_bubble, wb_en} !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl cycle %0d: got %b expected %b", cycle,
                             {pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_bubble, wb_en}, e.ctl);
                end
                checks++;
                if (state !== e.st) begin
                    errors++;
                    $display("FAIL state cycle %0d: got %0d expected %0d", cycle, state, e.st);
                end
                checks++;
                if (stall_cnt !== e.sc) begin
                    errors++;
                    $display("FAIL stall_cnt cycle %0d: got %0d expected %0d", cycle, stall_cnt, e.sc);
                end
                checks++;
                if (flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL flush_cnt cycle %0d: got %0d expected %0d", cycle, flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin
        bit frz;
        rst_n = 1'b0; id_op = '0; id_rs = '0; id_rt = '0; ex_regwrite = 1'b0;
        ex_wr = '0; ex_br_taken = 1'b0; dbg_freeze = 1'b0; dbg_step = 1'b0;

        cyc(1, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0);
        cyc(1, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0);
        idle(2);

        // and $t3,$t1,$t2 in ID while addi $t1 is in EX: three bubbles.
        cyc(0, 4'b0010, 2'd1, 2'd2, 1, 2'd1, 0, 0, 0);
        cyc(0, 4'b0010, 2'd1, 2'd2, 0, 2'd0, 0, 0, 0);
        cyc(0, 4'b0010, 2'd1, 2'd2, 0, 2'd0, 0, 0, 0);
        cyc(0, 4'b0010, 2'd1, 2'd2, 0, 2'd0, 0, 0, 0);
        check_val("stall_after_raw", int'(stall_cnt), 3);

        // addi $t2,$0,1 against EX writing $t2, then EX writing $0: no hazard.
        cyc(0, 4'b0100, 2'd0, 2'd2, 1, 2'd2, 0, 0, 0);
        cyc(0, 4'b0100, 2'd0, 2'd2, 1, 2'd0, 0, 0, 0);
        cyc(0, 4'b0000, 2'd1, 2'd1, 1, 2'd0, 0, 0, 0);

        // Taken beq in EX while ID hazards: flush wins, no stall counted.
        cyc(0, 4'b0000, 2'd1, 2'd2, 1, 2'd1, 1, 0, 0);
        idle(1);
        check_val("flush_after_beq", int'(flush_cnt), 1);
        cyc(0, 4'b0000, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0);
        check_val("stall_kept_beq", int'(stall_cnt), 3);

        // Hazard with freeze requested, two single steps, then release.
        cyc(0, 4'b0001, 2'd3, 2'd0, 1, 2'd3, 0, 1, 0);
        cyc(0, 4'b0001, 2'd3, 2'd0, 0, 2'd0, 0, 1, 0);
        cyc(0, 4'b0001, 2'd3, 2'd0, 0, 2'd0, 0, 1, 1);
        cyc(0, 4'b0001, 2'd3, 2'd0, 0, 2'd0, 0, 1, 0);
        cyc(0, 4'b0001, 2'd3, 2'd0, 0, 2'd0, 0, 1, 1);
        cyc(0, 4'b0001, 2'd3, 2'd0, 0, 2'd0, 0, 0, 0);
        idle(2);

        // Drive the stall counter into saturation.
        for (int i = 0; i < 6; i++) begin
            cyc(0, 4'b0110, 2'd0, 2'd2, 1, 2'd2, 0, 0, 0);
            idle(2);
        end
        idle(1);
        check_val("stall_saturated", int'(stall_cnt), CMAX);

        // Asynchronous reset asserted in the middle of a stall.
        cyc(0, 4'b1000, 2'd1, 2'd3, 1, 2'd3, 0, 0, 0);
        cyc(1, 4'b1000, 2'd1, 2'd3, 0, 2'd0, 0, 0, 0);
        idle(1);

        // Randomized traffic.
        frz = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) frz = ~frz;
            cyc($urandom_range(0, 249) == 0, 4'($urandom), 2'($urandom), 2'($urandom),
                1'($urandom), 2'($urandom), $urandom_range(0, 7) == 0, frz,
                $urandom_range(0, 2) == 0);
        end

        idle(2);
        @(posedge clk);
        #4;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
